// File: rtl/lcd_page_streamer.sv
// lcd_page_streamer: local 8-page framebuffer plus a streamer that feeds one
// page segment (page cmd, column cmds, then data bytes) to the LCD SPI engine.
//
// Ports:
//   i_sysclk, i_sysrst          clock, synchronous active-high reset
//   i_fb_we/i_fb_addr/i_fb_din  framebuffer write port, addr = {page, col}
//   i_upd_start/page/col_first/col_last
//                               segment update request (col_last inclusive)
//   o_upd_busy                  update in progress
//   o_upd_done                  1-cycle pulse after the last data byte
//   o_err                       1-cycle pulse when a request is rejected
//   o_tx_valid/o_tx_data/o_tx_cd, i_tx_ready
//                               byte handshake to the SPI engine (cd: 0=cmd)
module lcd_page_streamer #(
    parameter int C_COLS  = 102,
    parameter int C_PAGES = 8
) (
    input  logic       i_sysclk,
    input  logic       i_sysrst,
    input  logic       i_fb_we,
    input  logic [9:0] i_fb_addr,
    input  logic [7:0] i_fb_din,
    input  logic       i_upd_start,
    input  logic [2:0] i_upd_page,
    input  logic [6:0] i_upd_col_first,
    input  logic [6:0] i_upd_col_last,
    output logic       o_upd_busy,
    output logic       o_upd_done,
    output logic       o_err,
    output logic       o_tx_valid,
    output logic [7:0] o_tx_data,
    output logic       o_tx_cd,
    input  logic       i_tx_ready
);

    localparam logic [7:0] COLS_LIM  = 8'(C_COLS);
    localparam logic [3:0] PAGES_LIM = 4'(C_PAGES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD_PAGE,
        S_CMD_COLL,
        S_CMD_COLH,
        S_RD,
        S_DATA
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] page_q, page_d;
    logic [6:0] col_first_q, col_first_d;
    logic [6:0] col_last_q, col_last_d;
    logic [6:0] col_q, col_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic [7:0] fb_mem [0:1023];
    logic [7:0] ram_dout_q;
    logic [9:0] rd_addr;

    logic req_ok;
    logic xfer;

    // ------------------------------------------------------------------
    // Framebuffer: one write port open in every state, one read port used
    // only in RD. Both act on the same edge, so a write to the address
    // being read in RD returns the old byte. Contents survive reset.
    // ------------------------------------------------------------------
    assign rd_addr = {page_q, col_q};

    always_ff @(posedge i_sysclk) begin
        if (i_fb_we) begin
            fb_mem[i_fb_addr] <= i_fb_din;
        end
    end

    // The read register only loads in RD, so it holds the data byte
    // steady for the whole DATA state, however long the engine stalls.
    always_ff @(posedge i_sysclk) begin
        if (state_q == S_RD) begin
            ram_dout_q <= fb_mem[rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Request check and handshake
    // ------------------------------------------------------------------
    assign req_ok = (i_upd_col_first <= i_upd_col_last)
                 && ({1'b0, i_upd_col_last} < COLS_LIM)
                 && ({1'b0, i_upd_page} < PAGES_LIM);

    assign xfer = o_tx_valid & i_tx_ready;

    // ------------------------------------------------------------------
    // Byte output: decoded from registered state only, so data/cd cannot
    // change while valid is waiting for ready.
    // ------------------------------------------------------------------
    always_comb begin
        o_tx_valid = 1'b0;
        o_tx_cd    = 1'b0;
        o_tx_data  = 8'h00;
        unique case (state_q)
            S_CMD_PAGE: begin
                o_tx_valid = 1'b1;
                o_tx_data  = {5'b10110, page_q};
            end
            S_CMD_COLL: begin
                o_tx_valid = 1'b1;
                o_tx_data  = {4'h0, col_first_q[3:0]};
            end
            S_CMD_COLH: begin
                o_tx_valid = 1'b1;
                o_tx_data  = {5'b00010, col_first_q[6:4]};
            end
            S_DATA: begin
                o_tx_valid = 1'b1;
                o_tx_cd    = 1'b1;
                o_tx_data  = ram_dout_q;
            end
            default: begin
                o_tx_valid = 1'b0;
            end
        endcase
    end

    assign o_upd_busy = (state_q != S_IDLE);
    assign o_upd_done = done_q;
    assign o_err      = err_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        col_first_d = col_first_q;
        col_last_d  = col_last_q;
        col_d       = col_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Starts are only looked at here; while busy they are
                // dropped without an error.
                if (i_upd_start) begin
                    if (req_ok) begin
                        page_d      = i_upd_page;
                        col_first_d = i_upd_col_first;
                        col_last_d  = i_upd_col_last;
                        state_d     = S_CMD_PAGE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CMD_PAGE: begin
                if (xfer) begin
                    state_d = S_CMD_COLL;
                end
            end
            S_CMD_COLL: begin
                if (xfer) begin
                    state_d = S_CMD_COLH;
                end
            end
            S_CMD_COLH: begin
                if (xfer) begin
                    col_d   = col_first_q;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                if (xfer) begin
                    if (col_q == col_last_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // col_last < C_COLS <= 128, so no wrap here.
                        col_d   = col_q + 7'd1;
                        state_d = S_RD;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            state_q     <= S_IDLE;
            page_q      <= 3'd0;
            col_first_q <= 7'd0;
            col_last_q  <= 7'd0;
            col_q       <= 7'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            page_q      <= page_d;
            col_first_q <= col_first_d;
            col_last_q  <= col_last_d;
            col_q       <= col_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_lcd_page_streamer.sv
// tb_lcd_page_streamer: scoreboard bench for lcd_page_streamer.
// Expected bytes are queued at each request and popped on every handshake.
module tb_lcd_page_streamer;

    logic       clk;
    logic       i_sysrst;
    logic       i_fb_we;
    logic [9:0] i_fb_addr;
    logic [7:0] i_fb_din;
    logic       i_upd_start;
    logic [2:0] i_upd_page;
    logic [6:0] i_upd_col_first;
    logic [6:0] i_upd_col_last;
    logic       o_upd_busy;
    logic       o_upd_done;
    logic       o_err;
    logic       o_tx_valid;
    logic [7:0] o_tx_data;
    logic       o_tx_cd;
    logic       i_tx_ready;

    lcd_page_streamer #(
        .C_COLS (102),
        .C_PAGES(8)
    ) dut (
        .i_sysclk       (clk),
        .i_sysrst       (i_sysrst),
        .i_fb_we        (i_fb_we),
        .i_fb_addr      (i_fb_addr),
        .i_fb_din       (i_fb_din),
        .i_upd_start    (i_upd_start),
        .i_upd_page     (i_upd_page),
        .i_upd_col_first(i_upd_col_first),
        .i_upd_col_last (i_upd_col_last),
        .o_upd_busy     (o_upd_busy),
        .o_upd_done     (o_upd_done),
        .o_err          (o_err),
        .o_tx_valid     (o_tx_valid),
        .o_tx_data      (o_tx_data),
        .o_tx_cd        (o_tx_cd),
        .i_tx_ready     (i_tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] sb_q [$];
    logic [7:0] fb_m [0:1023];
    int         n_chk;
    int         n_pass;
    int         err_cnt;
    int         done_cnt;

    int         cfg_mode;
    int         cfg_poke;
    int         cfg_wr_k;
    logic [7:0] cfg_wr_v;
    int         cfg_rst_k;
    int         cfg_chain;
    logic [2:0] ch_p;
    logic [6:0] ch_f;
    logic [6:0] ch_l;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Handshake monitor: pops the scoreboard on every transfer and checks
    // that a stalled byte stays valid and unchanged.
    initial begin
        logic       prev_stall;
        logic [8:0] prev_byte;
        logic [8:0] exp;
        prev_stall = 1'b0;
        prev_byte  = 9'd0;
        forever begin
            @(negedge clk);
            if (i_sysrst) begin
                prev_stall = 1'b0;
                continue;
            end
            if (o_err) err_cnt++;
            if (o_upd_done) done_cnt++;
            if (prev_stall) begin
                check("hold_valid", o_tx_valid, 1);
                check("hold_byte", {o_tx_cd, o_tx_data}, prev_byte);
            end
            if (o_tx_valid && i_tx_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_extra", sb_q.size(), 1);
                end else begin
                    exp = sb_q.pop_front();
                    check("byte", {o_tx_cd, o_tx_data}, exp);
                end
            end
            prev_stall = o_tx_valid && !i_tx_ready;
            prev_byte  = {o_tx_cd, o_tx_data};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fb_write(input logic [9:0] a, input logic [7:0] d);
        i_fb_we   = 1'b1;
        i_fb_addr = a;
        i_fb_din  = d;
        fb_m[a]   = d;
        step();
        i_fb_we   = 1'b0;
    endtask

    // Queues the expected stream and raises start for the current cycle.
    task automatic start_req(input logic [2:0] p, input logic [6:0] f,
                             input logic [6:0] l);
        logic [7:0] b;
        sb_q.push_back({1'b0, 5'b10110, p});
        sb_q.push_back({1'b0, 4'h0, f[3:0]});
        sb_q.push_back({1'b0, 5'b00010, f[6:4]});
        for (int c = int'(f); c <= int'(l); c++) begin
            b = fb_m[{p, 7'(c)}];
            if (cfg_wr_k > 0 && cfg_wr_k < 4 && c == int'(f)) b = cfg_wr_v;
            sb_q.push_back({1'b1, b});
        end
        i_upd_start     = 1'b1;
        i_upd_page      = p;
        i_upd_col_first = f;
        i_upd_col_last  = l;
    endtask

    // Runs cycles 1.. of a started request; returns at the negedge of the
    // done cycle (or of the cycle after a planted reset).
    task automatic wait_req(input logic [2:0] p, input logic [6:0] f,
                            input int exp_done, input string tag);
        int   done_k;
        logic busy_prev;
        done_k    = 0;
        busy_prev = 1'b0;
        step();
        for (int k = 1; k <= 3000; k++) begin
            case (cfg_mode)
                0: i_tx_ready = 1'b1;
                1: i_tx_ready = !(k >= 3 && k <= 7);
                default: begin
                    if (k >= 3 && k <= 7) i_tx_ready = 1'b0;
                    else if (k < 8) i_tx_ready = 1'b1;
                    else i_tx_ready = 1'($urandom_range(0, 1));
                end
            endcase
            i_upd_start = 1'b0;
            i_sysrst    = (cfg_rst_k != 0 && k == cfg_rst_k);
            if (cfg_poke != 0 && k == 10) begin
                i_upd_start     = 1'b1;
                i_upd_page      = p + 3'd1;
                i_upd_col_first = 7'd0;
                i_upd_col_last  = 7'd5;
            end
            if (cfg_chain != 0 && k == exp_done) begin
                check({tag, "_chain_drained"}, sb_q.size(), 0);
                start_req(ch_p, ch_f, ch_l);
            end
            i_fb_we = (k == cfg_wr_k);
            if (k == cfg_wr_k) begin
                i_fb_addr       = {p, f};
                i_fb_din        = cfg_wr_v;
                fb_m[{p, f}]    = cfg_wr_v;
            end
            @(negedge clk);
            if (k == 1) begin
                check({tag, "_busy1"}, o_upd_busy, 1);
                check({tag, "_valid1"}, o_tx_valid, 1);
            end
            if (cfg_rst_k != 0 && k == cfg_rst_k + 1) begin
                check({tag, "_rst_valid"}, o_tx_valid, 0);
                check({tag, "_rst_busy"}, o_upd_busy, 0);
                sb_q.delete();
                done_k = -1;
                break;
            end
            if (o_upd_done) begin
                done_k = k;
                check({tag, "_busy_at_done"}, o_upd_busy, 0);
                check({tag, "_busy_before"}, busy_prev, 1);
                break;
            end
            busy_prev = o_upd_busy;
            step();
        end
        i_fb_we = 1'b0;
        if (done_k == 0) begin
            check({tag, "_timeout"}, done_k, 1);
        end else if (done_k > 0) begin
            if (exp_done > 0) check({tag, "_done_cycle"}, done_k, exp_done);
            if (cfg_chain == 0) check({tag, "_drained"}, sb_q.size(), 0);
        end
    endtask

    task automatic bad_req(input logic [6:0] f, input logic [6:0] l,
                           input string tag);
        i_upd_start     = 1'b1;
        i_upd_page      = 3'd2;
        i_upd_col_first = f;
        i_upd_col_last  = l;
        step();
        i_upd_start = 1'b0;
        @(negedge clk);
        check({tag, "_err"}, o_err, 1);
        check({tag, "_valid"}, o_tx_valid, 0);
        check({tag, "_busy"}, o_upd_busy, 0);
        step();
        @(negedge clk);
        check({tag, "_err_pulse"}, o_err, 0);
        check({tag, "_valid2"}, o_tx_valid, 0);
        step();
    endtask

    initial begin
        int err_before;
        int done_before;
        n_chk           = 0;
        n_pass          = 0;
        err_cnt         = 0;
        done_cnt        = 0;
        cfg_mode        = 0;
        cfg_poke        = 0;
        cfg_wr_k        = 0;
        cfg_wr_v        = 8'h00;
        cfg_rst_k       = 0;
        cfg_chain       = 0;
        ch_p            = 3'd0;
        ch_f            = 7'd0;
        ch_l            = 7'd0;
        i_sysrst        = 1'b1;
        i_fb_we         = 1'b0;
        i_fb_addr       = 10'd0;
        i_fb_din        = 8'd0;
        i_upd_start     = 1'b0;
        i_upd_page      = 3'd0;
        i_upd_col_first = 7'd0;
        i_upd_col_last  = 7'd0;
        i_tx_ready      = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", o_tx_valid, 0);
        check("rst_data", o_tx_data, 0);
        check("rst_cd", o_tx_cd, 0);
        check("rst_busy", o_upd_busy, 0);
        check("rst_done", o_upd_done, 0);
        check("rst_err", o_err, 0);
        step();
        i_sysrst = 1'b0;
        step();

        for (int c = 0; c < 102; c++) fb_write({3'd2, 7'(c)}, 8'(c) ^ 8'h55);
        fb_write({3'd7, 7'd90}, 8'hA3);
        for (int c = 20; c <= 40; c++)
            fb_write({3'd4, 7'(c)}, 8'($urandom_range(0, 255)));
        for (int c = 0; c < 16; c++)
            fb_write({3'd5, 7'(c)}, 8'($urandom_range(0, 255)));

        // Full page, ready always high.
        start_req(3'd2, 7'd0, 7'd101);
        wait_req(3'd2, 7'd0, 208, "full");
        step();

        // Single byte at the far end of the page.
        start_req(3'd7, 7'd90, 7'd90);
        wait_req(3'd7, 7'd90, 6, "single");
        step();

        // Write in the RD cycle returns the old byte, later reads see it.
        cfg_wr_k = 4;
        cfg_wr_v = 8'h3C;
        start_req(3'd7, 7'd90, 7'd90);
        wait_req(3'd7, 7'd90, 6, "rd_first");
        step();
        cfg_wr_k = 0;
        start_req(3'd7, 7'd90, 7'd90);
        wait_req(3'd7, 7'd90, 6, "rd_after");
        step();

        // Write one cycle before RD is reflected.
        cfg_wr_k = 3;
        cfg_wr_v = 8'hC5;
        start_req(3'd7, 7'd90, 7'd90);
        wait_req(3'd7, 7'd90, 6, "wr_early");
        step();
        cfg_wr_k = 0;

        // Five-cycle stall on the high column command.
        cfg_mode = 1;
        start_req(3'd4, 7'd20, 7'd40);
        wait_req(3'd4, 7'd20, 51, "stall5");
        step();

        // Same, then random ready through the data phase.
        cfg_mode = 2;
        start_req(3'd4, 7'd20, 7'd40);
        wait_req(3'd4, 7'd20, 0, "rand");
        cfg_mode   = 0;
        i_tx_ready = 1'b1;
        step();

        bad_req(7'd10, 7'd9, "bad_order");
        bad_req(7'd0, 7'd102, "bad_range");
        check("bad_err_count", err_cnt, 2);

        // Start while busy is ignored silently.
        err_before = err_cnt;
        cfg_poke   = 1;
        start_req(3'd2, 7'd0, 7'd20);
        wait_req(3'd2, 7'd0, 46, "poke");
        cfg_poke = 0;
        check("poke_no_err", err_cnt, err_before);
        step();

        // Start in the done cycle is accepted.
        cfg_chain = 1;
        ch_p      = 3'd7;
        ch_f      = 7'd90;
        ch_l      = 7'd90;
        start_req(3'd5, 7'd0, 7'd15);
        wait_req(3'd5, 7'd0, 36, "chain_a");
        cfg_chain = 0;
        wait_req(3'd7, 7'd90, 6, "chain_b");
        step();

        // Reset during the 3rd data byte, then repeat the segment.
        done_before = done_cnt;
        cfg_rst_k   = 9;
        start_req(3'd2, 7'd0, 7'd10);
        wait_req(3'd2, 7'd0, 0, "rst");
        cfg_rst_k = 0;
        repeat (5) step();
        @(negedge clk);
        check("rst_no_done", done_cnt, done_before);
        check("rst_idle", o_upd_busy, 0);
        step();
        start_req(3'd2, 7'd0, 7'd10);
        wait_req(3'd2, 7'd0, 26, "after_rst");
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
